bit_serial_mul: RTL and testbench

- Bit-serial unsigned multiplier: parallel multiplicand a times serial multiplier x.
- x enters one bit per clock on x_bit, LSB first.
- Product leaves one bit per clock on registered output y, LSB first.
- Used in area-constrained datapaths; runs continuously with no start/valid framing. Frames are defined by the caller feeding 2W-1 (or 2W) bit slots.

---
 rtl/bit_serial_mul.sv | 51 +++++
 tb/tb_bit_serial_mul.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bit_serial_mul.sv
// ============================================================================
//  Module   : bit_serial_mul
//  Purpose  : Bit-serial unsigned multiplier. Parallel multiplicand a times a
//             multiplier x presented LSB first on x_bit; the product leaves
//             LSB first on the registered output y.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bit_serial_mul #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] a,
  input  logic         x_bit,
  output logic         y
);

  logic [W:0] acc_q;
  logic [W:0] acc_d;
  logic       y_q;
  logic       y_d;
  logic [W:0] w_addend;
  logic [W:0] w_sum;

  // The carried-down partial sum stays below 2^W, so adding one more
  // W-bit partial product always fits in W+1 bits.
  always_comb begin
    w_addend = x_bit ? {1'b0, a} : '0;
    w_sum    = acc_q + w_addend;
    y_d      = w_sum[0];
    acc_d    = w_sum >> 1;
  end

  // rst_n is active-high despite its name.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      acc_q <= '0;
      y_q   <= 1'b0;
    end else begin
      acc_q <= acc_d;
      y_q   <= y_d;
    end
  end

  assign y = y_q;

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_mul.sv
// ============================================================================
//  Module   : tb_bit_serial_mul
//  Purpose  : Self-checking bench for bit_serial_mul against an arithmetic
//             product model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_mul;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a_in;
  logic         x_in;
  logic         y;

  int n_cmp;
  int n_fail;

  bit_serial_mul #(.W(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a_in),
    .x_bit(x_in),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected low ncyc bits of the product, from plain arithmetic.
  function automatic logic [63:0] ref_prod(input logic [W-1:0] fa,
                                           input logic [W-1:0] fx,
                                           input int ncyc);
    logic [63:0] p;
    logic [63:0] mask;
    p    = 64'(fa) * 64'(fx);
    mask = (ncyc >= 64) ? '1 : ((64'd1 << ncyc) - 64'd1);
    return p & mask;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame of ncyc bit slots; collect y after each edge.
  task automatic run_frame(input logic [W-1:0] fa, input logic [W-1:0] fx,
                           input int ncyc, output logic [63:0] got);
    got = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      a_in = fa;
      x_in = (i < W) ? fx[i] : 1'b0;
      @(posedge clk);
      #1;
      got[i] = y;
    end
  endtask

  initial begin
    logic [63:0] got;
    logic [63:0] exp;
    logic [W-1:0] ra;
    logic [W-1:0] rx;

    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    a_in   = 16'hFFFF;
    x_in   = 1'b1;

    // Held in reset with active inputs: y must stay 0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      x_in = i[0] ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
      check("reset_hold_y", {63'd0, y}, 64'd0);
    end

    @(negedge clk);
    rst_n = 1'b0;
    a_in  = 16'd1;
    x_in  = 1'b1;
    @(posedge clk);
    #1;
    check("first_edge_after_reset", {63'd0, y}, 64'd1);
    @(negedge clk);
    x_in = 1'b0;
    a_in = '0;
    @(posedge clk);
    #1;
    check("acc_clear_after_first", {63'd0, y}, 64'd0);

    // 3 * 5 bit by bit.
    run_frame(16'd3, 16'd5, 31, got);
    exp = ref_prod(16'd3, 16'd5, 31);
    for (int i = 0; i < 31; i++)
      check($sformatf("a3x5_bit%0d", i), {63'd0, got[i]}, {63'd0, exp[i]});

    // Back-to-back frames without reset.
    run_frame(16'd1024, 16'd1024, 31, got);
    check("b2b_1024x1024", got, ref_prod(16'd1024, 16'd1024, 31));
    run_frame(16'd7, 16'd9, 31, got);
    check("b2b_7x9", got, ref_prod(16'd7, 16'd9, 31));

    // Full-width operands need the 32nd slot for the top product bit.
    run_frame(16'hFFFF, 16'hFFFF, 32, got);
    exp = ref_prod(16'hFFFF, 16'hFFFF, 32);
    check("max_full", got, exp);
    check("max_bit31", {63'd0, got[31]}, {63'd0, exp[31]});
    run_frame(16'd1, 16'd1, 31, got);
    check("after_max_1x1", got, ref_prod(16'd1, 16'd1, 31));

    // Asynchronous clear while y is 1.
    run_frame(16'd1, 16'd1, 1, got);
    check("pre_async_y", got, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async_clear_y", {63'd0, y}, 64'd0);
    @(negedge clk);
    rst_n = 1'b0;

    // Reset mid-frame discards the partial product.
    run_frame(16'd1000, 16'd1000, 8, got);
    check("mid_partial_8", got, ref_prod(16'd1000, 16'd1000, 8));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_reset_y", {63'd0, y}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_reset_hold_y", {63'd0, y}, 64'd0);
    @(negedge clk);
    rst_n = 1'b0;
    x_in  = 1'b0;
    a_in  = '0;
    run_frame(16'd2, 16'd3, 31, got);
    check("after_mid_2x3", got, ref_prod(16'd2, 16'd3, 31));

    // Zero operands keep y at 0.
    run_frame(16'd0, 16'hFFFF, 31, got);
    check("zero_a", got, 64'd0);
    run_frame(16'hABCD, 16'd0, 31, got);
    check("zero_x", got, 64'd0);

    // Random regression.
    for (int f = 0; f < 1024; f++) begin
      ra = W'($urandom_range(1024, 0));
      rx = W'($urandom_range(1024, 0));
      run_frame(ra, rx, 31, got);
      check($sformatf("rand%0d_%0dx%0d", f, ra, rx), got, ref_prod(ra, rx, 31));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
